axil_led_bank: RTL and testbench

AXI4-Lite register slave combining build-ID readback (git hash, timestamp) with a parametrised bank of NUM_CH LED output channels. Each channel drives its LED from an internal programmable blinker or from one of NUM_SRC external sources, such as reconfigurable-partition LED counters, selected by register. A built-in quiesce port blocks new AXI transactions during DFX reconfiguration. Sits at top level behind the PS AXI-Lite master port.

---
 rtl/axil_led_bank.sv | 199 +++++++++++++++++++
 tb/tb_axil_led_bank.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_led_bank.sv
// AXI4-Lite register slave: build-ID readback plus a bank of LED channels, each
// driven by a per-channel blinker or a selectable external source, with a DFX quiesce port.
module axil_led_bank #(
  parameter int NUM_CH     = 2,
  parameter int NUM_SRC    = 3,
  parameter int CNT_W      = 27,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                      clk100,
  input  logic                      rstn,
  input  logic [63:0]               git_hash,
  input  logic [31:0]               timestamp,
  input  logic [NUM_CH*NUM_SRC-1:0] led_src_i,
  output logic [NUM_CH-1:0]         led_o,
  input  logic                      shutdown_req_i,
  output logic                      in_shutdown_o,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam logic [31:0] CFG_MASK = 32'h801F_000F;
  localparam int unsigned CMAX     = CNT_W - 1;

  typedef enum logic [1:0] {RUN, DRAIN, QUIET} state_t;

  state_t           state, state_d;
  logic             quiescing, drained;
  logic             wr_hs, rd_hs, wr_mapped, rd_err;
  logic [4:0]       wr_idx, rd_idx;
  logic [31:0]      rd_val;
  logic [31:0]      scratch, scratch_d;
  logic [31:0]      cfg   [NUM_CH];
  logic [31:0]      cfg_d [NUM_CH];
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] led_d;
  logic             unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  // The request cycle itself already blocks new handshakes, so nothing can be
  // accepted in the cycle the FSM decides it is drained.
  assign quiescing     = (state != RUN) || shutdown_req_i;
  assign wr_hs         = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !quiescing;
  assign rd_hs         = s_axi_arvalid && !s_axi_rvalid && !quiescing;
  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = rd_hs;
  assign wr_idx        = s_axi_awaddr[6:2];
  assign rd_idx        = s_axi_araddr[6:2];
  assign in_shutdown_o = (state == QUIET);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb, input logic [31:0] mask);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r & mask;
  endfunction

  always_comb begin
    scratch_d = scratch;
    wr_mapped = 1'b0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      cfg_d[n] = cfg[n];
      cnt_d[n] = cnt[n] + CNT_W'(1);
    end
    if (wr_idx == 5'd4) begin
      wr_mapped = 1'b1;
      if (wr_hs) scratch_d = merge(scratch, s_axi_wdata, s_axi_wstrb, '1);
    end
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (32'(wr_idx) == 8 + n) begin
        wr_mapped = 1'b1;
        if (wr_hs) begin
          cfg_d[n] = merge(cfg[n], s_axi_wdata, s_axi_wstrb, CFG_MASK);
          cnt_d[n] = '0;
        end
      end
    end
  end

  // LED register is loaded from next-cycle config and counter so the output
  // tracks a config write from the very cycle it becomes visible.
  always_comb begin
    logic [3:0]  sel;
    int unsigned div, idx;
    logic        b;
    led_d = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      sel = cfg_d[n][3:0];
      div = 32'(cfg_d[n][20:16]);
      if (div > CMAX) div = CMAX;
      idx = CMAX - div;
      b   = 1'b0;
      if (sel == 4'd0) begin
        for (int unsigned i = 0; i < CNT_W; i++)
          if (i == idx) b = cnt_d[n][i];
      end else begin
        for (int unsigned s = 0; s < NUM_SRC; s++)
          if (32'(sel) == s + 1) b = led_src_i[n*NUM_SRC + s];
      end
      led_d[n] = b ^ cfg_d[n][31];
    end
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_idx)
      5'd0: rd_val = git_hash[31:0];
      5'd1: rd_val = git_hash[63:32];
      5'd2: rd_val = timestamp;
      5'd3: begin
        rd_val[0]          = in_shutdown_o;
        rd_val[8 +: NUM_CH] = led_o;
      end
      5'd4: rd_val = scratch;
      default: rd_err = 1'b1;
    endcase
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (32'(rd_idx) == 8 + n) begin
        rd_val = cfg[n];
        rd_err = 1'b0;
      end
    end
  end

  // A response retiring this cycle counts as drained, so QUIET follows the last
  // B/R handshake by one cycle.
  always_comb begin
    drained = (!s_axi_bvalid || s_axi_bready) && (!s_axi_rvalid || s_axi_rready);
    state_d = state;
    case (state)
      RUN:     if (shutdown_req_i) state_d = drained ? QUIET : DRAIN;
      DRAIN:   if (!shutdown_req_i) state_d = RUN;
               else if (drained)    state_d = QUIET;
      QUIET:   if (!shutdown_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state        <= RUN;
      scratch      <= '0;
      led_o        <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= '0;
      s_axi_rdata  <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cfg[n] <= '0;
        cnt[n] <= '0;
      end
    end else begin
      state   <= state_d;
      scratch <= scratch_d;
      led_o   <= led_d;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cfg[n] <= cfg_d[n];
        cnt[n] <= cnt_d[n];
      end
      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_mapped ? 2'b00 : 2'b10;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
        s_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_led_bank.sv
// Directed bench for axil_led_bank: register map, blinker periods, source muxing,
// quiesce handshake blocking, and a per-cycle LED model comparison.
module tb_axil_led_bank;
  localparam int NCH  = 2;
  localparam int NSRC = 3;
  localparam int CW   = 8;

  logic clk100 = 1'b0;
  logic rstn;
  logic [63:0] git_hash;
  logic [31:0] timestamp;
  logic [NCH*NSRC-1:0] led_src_i;
  logic [NCH-1:0] led_o;
  logic shutdown_req_i, in_shutdown_o;
  logic [6:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  axil_led_bank #(.NUM_CH(NCH), .NUM_SRC(NSRC), .CNT_W(CW), .ADDR_WIDTH(7)) dut (
    .clk100(clk100), .rstn(rstn), .git_hash(git_hash), .timestamp(timestamp),
    .led_src_i(led_src_i), .led_o(led_o),
    .shutdown_req_i(shutdown_req_i), .in_shutdown_o(in_shutdown_o),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk100 = ~clk100;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: per channel, cycles since the last config write stand in for the counter.
  logic [31:0]   m_scratch;
  logic [31:0]   m_cfg [NCH];
  int            m_age [NCH];
  logic [NCH*NSRC-1:0] m_src_prev;
  logic [NCH-1:0] hist [64];
  logic [NCH-1:0] e_led;
  int nb = 0;
  int naw = 0;
  int widx, wrch;

  function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [NCH-1:0] model_led();
    logic [NCH-1:0] r;
    int sel, dv, b;
    r = '0;
    for (int n = 0; n < NCH; n++) begin
      sel = int'(m_cfg[n][3:0]);
      dv  = int'(m_cfg[n][20:16]);
      if (dv > CW - 1) dv = CW - 1;
      if (sel == 0)         b = ((m_age[n] % 256) >> (CW - 1 - dv)) & 1;
      else if (sel <= NSRC) b = int'(m_src_prev[n*NSRC + sel - 1]);
      else                  b = 0;
      r[n] = b[0] ^ m_cfg[n][31];
    end
    return r;
  endfunction

  always @(negedge clk100) begin
    if (!rstn) begin
      m_scratch  = '0;
      m_src_prev = '0;
      for (int n = 0; n < NCH; n++) begin m_cfg[n] = '0; m_age[n] = 0; end
    end else begin
      e_led = model_led();
      hist[cyc % 64] = e_led;
      check("led_o_model", 64'(led_o), 64'(e_led));
      if (bvalid && bready) nb++;
      wrch = -1;
      if (awvalid && awready && wvalid && wready) begin
        naw++;
        widx = int'(awaddr[6:2]);
        if (widx == 4) m_scratch = bytes_in(m_scratch, wdata, wstrb);
        else if (widx >= 8 && widx < 8 + NCH) begin
          m_cfg[widx-8] = bytes_in(m_cfg[widx-8], wdata, wstrb) & 32'h801F_000F;
          wrch = widx - 8;
        end
      end
      for (int n = 0; n < NCH; n++) m_age[n] = (n == wrch) ? 0 : m_age[n] + 1;
      m_src_prev = led_src_i;
    end
  end

  task automatic tick();
    @(posedge clk100); #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    int n;
    tick();
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk100);
    while (!(awready && wready) && n < 50) begin @(negedge clk100); n++; end
    if (n >= 50) check("wr_handshake", 64'(awready && wready), 64'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk100);
    check("bvalid_latency", 64'(bvalid), 64'd1);
    resp = bresp;
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    tick();
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk100);
    while (!arready && n < 50) begin @(negedge clk100); n++; end
    if (n >= 50) check("rd_handshake", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    @(negedge clk100);
    check("rvalid_latency", 64'(rvalid), 64'd1);
    d = rdata; resp = rresp;
  endtask

  task automatic run_len(input logic lvl, input int ch, output int n);
    n = 0;
    while (led_o[ch] === lvl && n < 400) begin @(negedge clk100); n++; end
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  int          n, nb0, naw0, c;
  logic        v;
  logic [4:0]  vec;
  logic [31:0] exp_st;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; git_hash = 64'h0123_4567_89AB_CDEF; timestamp = 32'h6600_1234;
    led_src_i = '0; shutdown_req_i = 1'b0;
    awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0;
    arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    check("rst_led_o", 64'(led_o), 64'd0);
    check("rst_in_shutdown", 64'(in_shutdown_o), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_resp", 64'({bresp, rresp}), 64'd0);
    tick();
    rstn = 1'b1;

    rd(7'h00, d, r); check("git_lo", 64'(d), 64'h89AB_CDEF); check("git_lo_resp", 64'(r), 64'd0);
    rd(7'h04, d, r); check("git_hi", 64'(d), 64'h0123_4567); check("git_hi_resp", 64'(r), 64'd0);
    rd(7'h08, d, r); check("tstamp", 64'(d), 64'h6600_1234); check("tstamp_resp", 64'(r), 64'd0);

    wr(7'h10, 32'hA5A5_A5A5, 4'b0101, r); check("scratch_wr_resp", 64'(r), 64'd0);
    rd(7'h10, d, r); check("scratch_strb", 64'(d), 64'h00A5_00A5);
    wr(7'h08, 32'hDEAD_BEEF, 4'hF, r); check("ro_wr_resp", 64'(r), 64'd2);
    wr(7'h7C, 32'hDEAD_BEEF, 4'hF, r); check("unmapped_wr_resp", 64'(r), 64'd2);
    rd(7'h08, d, r); check("tstamp_after_ro_wr", 64'(d), 64'h6600_1234);
    rd(7'h10, d, r); check("scratch_after_bad_wr", 64'(d), {32'd0, m_scratch});
    rd(7'h7C, d, r); check("unmapped_rdata", 64'(d), 64'd0); check("unmapped_rresp", 64'(r), 64'd2);

    wr(7'h20, 32'h0000_0000, 4'hF, r);
    check("blink_start", 64'(led_o[0]), 64'd0);
    run_len(1'b0, 0, n); check("blink_div0_low", 64'(n), 64'd128);
    wr(7'h20, 32'h0005_0000, 4'hF, r);
    run_len(1'b0, 0, n); check("blink_div5_low", 64'(n), 64'd4);
    run_len(1'b1, 0, n); check("blink_div5_high", 64'(n), 64'd4);
    wr(7'h20, 32'h001F_0000, 4'hF, r);
    run_len(1'b0, 0, n); check("blink_div31_low", 64'(n), 64'd1);
    run_len(1'b1, 0, n); check("blink_div31_high", 64'(n), 64'd1);
    rd(7'h20, d, r); check("cfg0_readback", 64'(d), 64'h001F_0000);

    vec = 5'b01101;
    wr(7'h24, 32'h0000_0003, 4'hF, r);
    for (int i = 0; i < 5; i++) begin
      v = vec[i];
      tick(); led_src_i = v ? 6'b100000 : 6'b011111;
      tick(); @(negedge clk100);
      check("src_follow", 64'(led_o[1]), 64'(v));
    end
    wr(7'h24, 32'h8000_0003, 4'hF, r);
    for (int i = 0; i < 5; i++) begin
      v = vec[i];
      tick(); led_src_i = v ? 6'b100000 : 6'b011111;
      tick(); @(negedge clk100);
      check("src_invert", 64'(led_o[1]), 64'(!v));
    end
    wr(7'h24, 32'h0000_0009, 4'hF, r);
    tick(); led_src_i = '1; tick(); @(negedge clk100);
    check("sel_out_of_range", 64'(led_o[1]), 64'd0);
    wr(7'h24, 32'hFFFF_FFFF, 4'hF, r);
    rd(7'h24, d, r); check("cfg1_mask", 64'(d), 64'h801F_000F);
    check("const0_inverted", 64'(led_o[1]), 64'd1);

    tick(); shutdown_req_i = 1'b1;
    @(negedge clk100); check("quiet_idle_T", 64'(in_shutdown_o), 64'd0);
    @(negedge clk100); check("quiet_idle_T1", 64'(in_shutdown_o), 64'd1);
    tick(); shutdown_req_i = 1'b0;
    @(negedge clk100); @(negedge clk100);
    check("quiet_idle_release", 64'(in_shutdown_o), 64'd0);

    bready = 1'b0;
    wr(7'h10, 32'h1111_1111, 4'hF, r);
    tick(); shutdown_req_i = 1'b1;
    tick();
    araddr = 7'h10; arvalid = 1'b1;
    awaddr = 7'h10; wdata = 32'h2222_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk100);
      check("drain_no_arready", 64'(arready), 64'd0);
      check("drain_no_awready", 64'(awready), 64'd0);
      check("drain_not_quiet", 64'(in_shutdown_o), 64'd0);
      check("drain_bvalid_held", 64'(bvalid), 64'd1);
    end
    tick(); bready = 1'b1;
    @(negedge clk100); check("drain_b_cycle", 64'(in_shutdown_o), 64'd0);
    @(negedge clk100); check("quiet_after_b", 64'(in_shutdown_o), 64'd1);
    check("quiet_no_arready", 64'(arready), 64'd0);
    tick(); awvalid = 1'b0; wvalid = 1'b0; shutdown_req_i = 1'b0;
    @(negedge clk100); check("release_cycle_blocked", 64'(arready), 64'd0);
    @(negedge clk100); check("release_in_shutdown", 64'(in_shutdown_o), 64'd0);
    check("release_arready", 64'(arready), 64'd1);
    tick(); arvalid = 1'b0;
    @(negedge clk100); check("release_rvalid", 64'(rvalid), 64'd1);
    check("release_rdata", 64'(rdata), 64'h1111_1111);

    tick(); nb0 = nb; naw0 = naw; led_src_i = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      tick();
      wvalid = 1'b1; wstrb = 4'hF;
      wdata = (k == 0) ? 32'h0002_0000 : (k == 1) ? 32'h0000_0001 : 32'hCAFE_F00D;
      awaddr = (k == 0) ? 7'h20 : (k == 1) ? 7'h24 : 7'h10;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk100); check("w_without_aw", 64'(wready), 64'd0);
      end
      tick(); awvalid = 1'b1;
      n = 0;
      @(negedge clk100);
      while (!(awready && wready) && n < 50) begin @(negedge clk100); n++; end
      if (n >= 50) check("b2b_handshake", 64'(awready && wready), 64'd1);
      tick(); awvalid = 1'b0; wvalid = 1'b0;
    end
    @(negedge clk100); @(negedge clk100); tick();
    check("b_count", 64'(nb - nb0), 64'd3);
    check("aw_count", 64'(naw - naw0), 64'd3);

    tick(); rready = 1'b0; araddr = 7'h0C; arvalid = 1'b1;
    n = 0;
    @(negedge clk100);
    while (!arready && n < 50) begin @(negedge clk100); n++; end
    c = cyc;
    tick(); arvalid = 1'b0;
    exp_st = '0; exp_st[8 +: NCH] = hist[c % 64];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk100);
      check("status_rvalid_hold", 64'(rvalid), 64'd1);
      check("status_rdata_stable", 64'(rdata), 64'(exp_st));
    end
    tick(); rready = 1'b1;
    @(negedge clk100); @(negedge clk100);
    check("rvalid_drop", 64'(rvalid), 64'd0);
    rd(7'h10, d, r); check("scratch_b2b", 64'(d), 64'hCAFE_F00D);
    rd(7'h24, d, r); check("cfg1_b2b", 64'(d), 64'h0000_0001);
    check("src0_ch1", 64'(led_o[1]), 64'd1);

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
